// File: rtl/tbird_pkg.sv
// Shared types and defaults for the Thunderbird tail-light block and its input conditioning.
package tbird_pkg;

  localparam int TBIRD_DB_CYCLES_DEF = 4;
  localparam int TBIRD_TICK_DIV_DEF  = 8;

  typedef enum logic [2:0] {
    TBIRD_IDLE = 3'd0,
    TBIRD_L1   = 3'd1,
    TBIRD_L2   = 3'd2,
    TBIRD_L3   = 3'd3,
    TBIRD_R1   = 3'd4,
    TBIRD_R2   = 3'd5,
    TBIRD_R3   = 3'd6,
    TBIRD_LR3  = 3'd7
  } t_tbird_lights_state;

  // Lamp pattern {LC, LB, LA, RA, RB, RC} shown in each FSM state.
  function automatic logic [5:0] tbird_lamps(input t_tbird_lights_state state);
    logic [5:0] lamps;
    lamps = 6'b000_000;
    case (state)
      TBIRD_L1:  lamps = 6'b001_000;
      TBIRD_L2:  lamps = 6'b011_000;
      TBIRD_L3:  lamps = 6'b111_000;
      TBIRD_R1:  lamps = 6'b000_100;
      TBIRD_R2:  lamps = 6'b000_110;
      TBIRD_R3:  lamps = 6'b000_111;
      TBIRD_LR3: lamps = 6'b111_111;
      default:   lamps = 6'b000_000;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/tbird_debounce.sv
// One switch channel: two-flop synchronizer followed by a counter that qualifies
// a level change only after DB_CYCLES consecutive disagreeing samples.
module tbird_debounce
  import tbird_pkg::*;
#(
  parameter int DB_CYCLES = TBIRD_DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1_reg;
  logic          s2_reg;
  logic          out_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg  <= 1'b0;
      s2_reg  <= 1'b0;
      out_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      s1_reg <= raw;
      s2_reg <= s1_reg;
      // Any agreeing sample restarts qualification, so short glitches never accumulate.
      if (s2_reg == out_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        out_reg <= s2_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = out_reg;

endmodule

// File: rtl/tbird_input_cond.sv
// Conditions the three tail-light switches (sync + debounce) and generates the
// periodic step enable that paces the tail-light FSM.
module tbird_input_cond
  import tbird_pkg::*;
#(
  parameter int DB_CYCLES = TBIRD_DB_CYCLES_DEF,
  parameter int TICK_DIV  = TBIRD_TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic left_raw,
  input  logic right_raw,
  input  logic haz_raw,
  output logic left,
  output logic right,
  output logic haz,
  output logic step
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_DIV - 1);

  logic [2:0] raw_vec;
  logic [2:0] level_vec;

  assign raw_vec = {haz_raw, right_raw, left_raw};

  // Channels are independent; left&right and hazard conflicts are the FSM's job.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      tbird_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw_vec[gi]),
        .level(level_vec[gi])
      );
    end
  endgenerate

  assign left  = level_vec[0];
  assign right = level_vec[1];
  assign haz   = level_vec[2];

  logic [TW-1:0] tcnt_reg;
  logic [TW-1:0] tcnt_next;
  logic          step_reg;

  always_comb begin
    tcnt_next = tcnt_reg + 1'b1;
    if (tcnt_reg == TCNT_LAST) begin
      tcnt_next = '0;
    end
  end

  // step is registered alongside tcnt so it is high exactly while tcnt holds its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_reg <= '0;
      step_reg <= 1'b0;
    end else begin
      tcnt_reg <= tcnt_next;
      step_reg <= (tcnt_next == TCNT_LAST);
    end
  end

  assign step = step_reg;

endmodule

// File: doc/tbird_input_cond.md
TBIRD_INPUT_COND -- requirements
Module: tbird_input_cond

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 4, giving the debounce qualification length in cycles (legal range 1..255).
REQ-002 The block SHALL have parameter TICK_DIV, default 8, giving the step-tick period in cycles (legal range 2..65535).
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Ports left_raw, right_raw, haz_raw, input, 1 bit each: asynchronous, bouncy switch levels.
REQ-006 Ports left, right, haz, output, 1 bit each: synchronized, debounced levels that feed the turn-signal FSM directly.
REQ-007 Port step, output, 1 bit: single-cycle pulse every TICK_DIV cycles, used as the FSM advance enable.

Function
REQ-008 Each raw input SHALL pass through a two-flop synchronizer (s1, then s2) before any other use.
REQ-009 Each channel SHALL hold a counter cnt of width $clog2(DB_CYCLES+1) and an output register out.
REQ-010 Each cycle, if s2 == out, the channel SHALL clear cnt to 0.
REQ-011 Each cycle, if s2 != out and cnt == DB_CYCLES-1, the channel SHALL set out <= s2 and clear cnt to 0.
REQ-012 Each cycle, if s2 != out and cnt < DB_CYCLES-1, the channel SHALL increment cnt.
REQ-013 Latency SHALL be exact: a raw level held stable from clock edge 1 (first sampling edge) changes out at edge DB_CYCLES+2, for both rising and falling transitions.
REQ-014 Any s2 excursion shorter than DB_CYCLES cycles SHALL restart qualification, leave out unchanged, and not saturate or wrap cnt.
REQ-015 The three channels SHALL be fully independent; simultaneous transitions on several inputs SHALL qualify concurrently with no priority or interlock (the FSM resolves left&right and haz).
REQ-016 The tick counter tcnt, of width $clog2(TICK_DIV), SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-017 step SHALL be 1 exactly in cycles where tcnt == TICK_DIV-1, and 0 otherwise.
REQ-018 The first step pulse SHALL occur TICK_DIV cycles after the cycle in which rst is deasserted; pulses SHALL then repeat every TICK_DIV cycles with no drift.
REQ-019 Debounced outputs SHALL change independently of step; they are not aligned to the tick.
REQ-020 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-021 While rst=1 at a rising edge: s1, s2, cnt, out and tcnt SHALL all clear to 0, so left=right=haz=step=0 in the following cycle.
REQ-022 rst asserted mid-qualification or mid-period SHALL discard partial counts; qualification SHALL restart from zero after release.
REQ-023 A raw input held at 1 through reset SHALL appear at its output exactly DB_CYCLES+2 edges after the first non-reset edge.

Structure
REQ-024 The per-input logic (synchronizer, counter, out register) SHALL be a sub-module tbird_debounce with parameter DB_CYCLES, instantiated three times.
REQ-025 Shared package tbird_pkg SHALL hold t_tbird_lights_state, TBIRD_DB_CYCLES_DEF = 4 and TBIRD_TICK_DIV_DEF = 8.
REQ-026 The tick generator SHALL live inline in tbird_input_cond.

Verification (DB_CYCLES=4, TICK_DIV=8 unless stated)
REQ-027 Reset, then left_raw 0->1 stable -> left rises at edge 6, right=haz=0 throughout.
REQ-028 haz_raw high for 3 cycles, then low -> haz stays 0, and cnt returns to 0.
REQ-029 right_raw toggling every 2 cycles for 20 cycles, then held 1 -> right=0 during toggling, then rises 6 edges after the final toggle.
REQ-030 left_raw and right_raw rise on the same edge -> left and right rise on the same edge 6.
REQ-031 rst pulsed for 1 cycle at cnt=2 with left_raw=1 held -> left=0, then left rises at edge 6 after release; step first fires 8 cycles after release.
REQ-032 Free-run 100 cycles after reset -> step high exactly in cycles 8, 16, ..., 96, each pulse 1 cycle wide.
